// File: rtl/seq_pkg.sv
// Shared types, instruction field layout and instruction builders for the
// sequencer, the cpu and the benches.
package seq_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_STRT  = 3'd2,
    S_WLOW  = 3'd3,
    S_WHIGH = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } seq_state_t;

  localparam int unsigned INSTR_W = 16;

  // Instruction field bit positions
  localparam int unsigned OPCODE_HI = 15;
  localparam int unsigned OPCODE_LO = 13;
  localparam int unsigned OP_HI     = 12;
  localparam int unsigned OP_LO     = 11;
  localparam int unsigned RN_HI     = 10;
  localparam int unsigned RN_LO     = 8;
  localparam int unsigned RD_HI     = 7;
  localparam int unsigned RD_LO     = 5;
  localparam int unsigned SH_HI     = 4;
  localparam int unsigned SH_LO     = 3;
  localparam int unsigned RM_HI     = 2;
  localparam int unsigned RM_LO     = 0;
  localparam int unsigned IMM8_HI   = 7;
  localparam int unsigned IMM8_LO   = 0;

  // Opcode / op encodings
  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // Shifter encodings applied to the Rm operand
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // Register-form instruction word
  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } instr_t;

  // MOV Rn,#imm8
  function automatic logic [INSTR_W-1:0] mov_imm(input logic [2:0] rn,
                                                 input logic [7:0] imm8);
    return {OPC_MOV, OP_MOV_IMM, rn, imm8};
  endfunction

  // ALU-class instruction: ADD/CMP/AND/MVN Rd,Rn,Rm{,shift}
  function automatic logic [INSTR_W-1:0] alu_instr(input logic [1:0] op,
                                                   input logic [2:0] rn,
                                                   input logic [2:0] rd,
                                                   input logic [1:0] sh,
                                                   input logic [2:0] rm);
    instr_t w;
    w.opcode = OPC_ALU;
    w.op     = op;
    w.rn     = rn;
    w.rd     = rd;
    w.sh     = sh;
    w.rm     = rm;
    return w;
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Small program store: one synchronous write port, one asynchronous read port.
module instr_mem
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata_c
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Write port; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Combinational read port
  assign rdata_c = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Issues a stored program to the cpu over its in/load/s/w handshake,
// one instruction at a time, with a per-phase timeout.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [AW:0]        count,
  input  logic               start,
  input  logic               cpu_w,
  output logic [INSTR_W-1:0] cpu_in,
  output logic               cpu_load,
  output logic               cpu_s,
  output logic [AW:0]        pc,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  seq_state_t         state;
  logic [PW-1:0]      count_q;
  logic [TW-1:0]      tmo;

  logic               wr_en_c;
  logic [PW-1:0]      pc_inc_c;
  logic [PW-1:0]      count_clamp_c;
  logic [AW-1:0]      ld_addr_c;
  logic [INSTR_W-1:0] mem_rd_c;
  logic [INSTR_W-1:0] ld_data_c;
  logic               start_ok_c;
  logic               tmo_hit_c;

  // Writes are locked out while a program is running
  assign wr_en_c = prog_we & ~busy;

  assign pc_inc_c      = pc + PW'(1);
  assign count_clamp_c = (count > DEPTH_P) ? DEPTH_P : count;
  assign start_ok_c    = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
  assign tmo_hit_c     = (tmo == TMO_LAST);

  // Address of the instruction about to be loaded: next pc from WHIGH, else 0
  assign ld_addr_c = (state == S_WHIGH) ? pc_inc_c[AW-1:0] : AW'(0);

  instr_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we      (wr_en_c),
    .waddr   (prog_addr),
    .wdata   (prog_data),
    .raddr   (ld_addr_c),
    .rdata_c (mem_rd_c)
  );

  // Forward a same-cycle write so the first LOAD sees the new word
  assign ld_data_c = (wr_en_c && (prog_addr == ld_addr_c)) ? prog_data : mem_rd_c;

  // Sequencer FSM with registered handshake outputs, pc and timeout counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      count_q  <= '0;
      tmo      <= '0;
      cpu_in   <= '0;
      cpu_load <= 1'b0;
      cpu_s    <= 1'b0;
      pc       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      cpu_load <= 1'b0;
      cpu_s    <= 1'b0;
      done     <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_ok_c) begin
            count_q <= count_clamp_c;
            pc      <= '0;
            err     <= 1'b0;
            if (count_clamp_c == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= S_LOAD;
              cpu_in   <= ld_data_c;
              cpu_load <= 1'b1;
              busy     <= 1'b1;
            end
          end else if (state == S_DONE) begin
            state <= S_IDLE;
          end
        end

        S_LOAD: begin
          state <= S_STRT;
          cpu_s <= 1'b1;
        end

        S_STRT: begin
          state <= S_WLOW;
          tmo   <= '0;
        end

        S_WLOW: begin
          if (!cpu_w) begin
            state <= S_WHIGH;
            tmo   <= '0;
          end else if (tmo_hit_c) begin
            state <= S_ERR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

        S_WHIGH: begin
          if (cpu_w) begin
            pc <= pc_inc_c;
            if (pc_inc_c == count_q) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= S_LOAD;
              cpu_in   <= ld_data_c;
              cpu_load <= 1'b1;
            end
          end else if (tmo_hit_c) begin
            state <= S_ERR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer with a behavioural cpu model attached.
module tb_instr_sequencer;
  import seq_pkg::*;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned TIMEOUT = 64;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          prog_we   = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [15:0]   prog_data = '0;
  logic [AW:0]   count     = '0;
  logic          start     = 1'b0;
  logic          cpu_w;
  logic [15:0]   cpu_in;
  logic          cpu_load;
  logic          cpu_s;
  logic [AW:0]   pc;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  instr_sequencer #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .count     (count),
    .start     (start),
    .cpu_w     (cpu_w),
    .cpu_in    (cpu_in),
    .cpu_load  (cpu_load),
    .cpu_s     (cpu_s),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural cpu ----------------
  logic [15:0] rf [8];
  logic [15:0] ir;
  int          cnt;
  bit          stuck     = 1'b0;
  int          fixed_lat = 0;
  int          lat_pick;
  int          lat_q[$];
  logic [15:0] issued[$];
  int          done_cnt = 0;

  function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] s);
    case (s)
      SH_LSL:  return {v[14:0], 1'b0};
      SH_LSR:  return {1'b0, v[15:1]};
      SH_ASR:  return {v[15], v[15:1]};
      default: return v;
    endcase
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  task automatic exec(input logic [15:0] i);
    instr_t d;
    logic [15:0] b;
    d = i;
    b = shf(rf[d.rm], d.sh);
    if (i[OPCODE_HI:OPCODE_LO] == OPC_MOV) begin
      if (i[OP_HI:OP_LO] == OP_MOV_IMM) rf[i[RN_HI:RN_LO]] = sext8(i[IMM8_HI:IMM8_LO]);
      else if (i[OP_HI:OP_LO] == OP_MOV_REG) rf[i[RD_HI:RD_LO]] = shf(rf[i[RM_HI:RM_LO]], i[SH_HI:SH_LO]);
    end else if (d.opcode == OPC_ALU) begin
      case (d.op)
        OP_ADD:  rf[d.rd] = rf[d.rn] + b;
        OP_AND:  rf[d.rd] = rf[d.rn] & b;
        OP_MVN:  rf[d.rd] = ~b;
        default: ;
      endcase
    end
  endtask

  // cpu: w high while waiting; s starts an execution lasting lat_pick cycles
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_w <= 1'b1;
      cnt   <= 0;
    end else begin
      if (cpu_load) ir <= cpu_in;
      if (stuck) begin
        cpu_w <= 1'b1;
      end else if (cpu_w && cpu_s) begin
        lat_pick = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 5));
        lat_q.push_back(lat_pick);
        cnt   <= lat_pick;
        cpu_w <= 1'b0;
      end else if (!cpu_w) begin
        if (cnt == 1) begin
          exec(ir);
          cpu_w <= 1'b1;
        end
        cnt <= cnt - 1;
      end
    end
  end

  // Monitor: record issued words and done pulses, load/s exclusivity
  always @(negedge clk) begin
    if (reset) begin
      if (cpu_load) issued.push_back(cpu_in);
      if (done) done_cnt++;
      total++;
      assert (!(cpu_load && cpu_s)) else begin
        bad++;
        $error("FAIL load_s_overlap observed=load%0b,s%0b expected=not both high", cpu_load, cpu_s);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_mem(input int a, input logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_data = d;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic kick(input int c);
    issued.delete();
    lat_q.delete();
    done_cnt = 0;
    count    = (AW+1)'(c);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    prog_we  = 1'b0;
  endtask

  task automatic wait_done(inout int n);
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  // Checks a finished run against the program and the cpu latencies it saw
  task automatic finish_run(input string tag, input int c, input logic [15:0] words[$], input int n);
    int d;
    d = 0;
    foreach (lat_q[k]) d += 3 + lat_q[k];
    chk({tag, "_instr_started"}, 32'(lat_q.size()), 32'(c));
    chk({tag, "_done_cycle"}, 32'(n), 32'(d + 1));
    chk({tag, "_pc"}, 32'(pc), 32'(c));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_issued_n"}, 32'(issued.size()), 32'(c));
    for (int k = 0; k < c && k < issued.size(); k++)
      chk({tag, "_issued_word"}, 32'(issued[k]), 32'(words[k]));
  endtask

  // Hard stop if something hangs
  initial begin
    #500000;
    $display("FAIL watchdog observed=no finish expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random steps ----------------
  initial begin
    int          n;
    int          seen;
    logic [15:0] prog5[$];
    logic [15:0] w[$];
    logic [15:0] exp_rf[8];
    bit          wr[8];
    int          c;
    int          ne;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cpu_in", 32'(cpu_in), 32'd0);
    chk("rst_cpu_load", 32'(cpu_load), 32'd0);
    chk("rst_cpu_s", 32'(cpu_s), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single MOV, written in the same cycle as start
    write_mem(0, 16'hD0FF);
    prog_we = 1'b1; prog_addr = '0; prog_data = 16'hD004;
    kick(1);
    n = 1;
    chk("mov_load_t1", 32'(cpu_load), 32'd1);
    chk("mov_in_t1", 32'(cpu_in), 32'hD004);
    chk("mov_s_t1", 32'(cpu_s), 32'd0);
    chk("mov_busy_t1", 32'(busy), 32'd1);
    @(negedge clk); n++;
    chk("mov_s_t2", 32'(cpu_s), 32'd1);
    chk("mov_load_t2", 32'(cpu_load), 32'd0);
    chk("mov_in_t2", 32'(cpu_in), 32'hD004);
    wait_done(n);
    w = {16'hD004};
    finish_run("mov", 1, w, n);
    chk("mov_r0", 32'(rf[0]), 32'h0004);

    // Zero count
    kick(0);
    n = 1;
    chk("zero_done_t1", 32'(done), 32'd1);
    chk("zero_busy_t1", 32'(busy), 32'd0);
    w = {};
    finish_run("zero", 0, w, n);

    // Five-instruction program, first interrupted by reset in WHIGH of instr 2
    prog5 = {16'hD124, 16'hD233, 16'hD302, 16'hA20B,
             alu_instr(OP_AND, 3'd2, 3'd3, SH_NONE, 3'd1), 16'hB860};
    foreach (prog5[k]) write_mem(k, prog5[k]);
    fixed_lat = 6;
    kick(6);
    seen = 0;
    ne   = 0;
    while (seen < 2 && ne < 500) begin
      @(negedge clk);
      ne++;
      if (cpu_s) seen++;
    end
    chk("rst_mid_reached", 32'(seen), 32'd2);
    repeat (3) @(negedge clk);
    chk("rst_mid_busy_pre", 32'(busy), 32'd1);
    chk("rst_mid_pc_pre", 32'(pc), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_cpu_in", 32'(cpu_in), 32'd0);
    chk("rst_mid_load", 32'(cpu_load), 32'd0);
    chk("rst_mid_s", 32'(cpu_s), 32'd0);
    chk("rst_mid_pc", 32'(pc), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    fixed_lat = 0;
    kick(6);
    n = 1;
    wait_done(n);
    finish_run("prog5", 6, prog5, n);
    chk("prog5_r0", 32'(rf[0]), 32'h0037);
    chk("prog5_r3", 32'(rf[3]), 32'hFFC8);
    chk("prog5_r1", 32'(rf[1]), 32'h0024);
    chk("prog5_r2", 32'(rf[2]), 32'h0033);

    // Timeout with w stuck high, then recovery
    stuck = 1'b1;
    kick(1);
    chk("tmo_load_t1", 32'(cpu_load), 32'd1);
    @(negedge clk);
    chk("tmo_s_t2", 32'(cpu_s), 32'd1);
    repeat (TIMEOUT) @(negedge clk);
    chk("tmo_err_early", 32'(err), 32'd0);
    chk("tmo_busy_early", 32'(busy), 32'd1);
    @(negedge clk);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_pc", 32'(pc), 32'd0);
    chk("tmo_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("tmo_err_sticky", 32'(err), 32'd1);
    stuck = 1'b0;
    kick(1);
    n = 1;
    chk("tmo_err_cleared", 32'(err), 32'd0);
    wait_done(n);
    w = {16'hD124};
    finish_run("tmo_recover", 1, w, n);

    // start / prog_we pulses while busy are ignored
    w = {};
    for (int k = 0; k < 4; k++) begin
      w.push_back(mov_imm(3'(k + 4), 8'($urandom)));
      write_mem(k, w[k]);
    end
    fixed_lat = 3;
    kick(4);
    n = 1;
    repeat (3) begin @(negedge clk); n++; end
    chk("busy_mid_run", 32'(busy), 32'd1);
    start = 1'b1; count = (AW+1)'(2);
    prog_we = 1'b1; prog_addr = '0; prog_data = ~w[0];
    @(negedge clk); n++;
    start = 1'b0; prog_we = 1'b0;
    wait_done(n);
    finish_run("busy_ign", 4, w, n);
    fixed_lat = 0;
    kick(1);
    n = 1;
    wait_done(n);
    finish_run("busy_ign_mem", 1, w, n);

    // Random MOV programs, including full depth and a clamped count
    for (int it = 0; it < 6; it++) begin
      c = (it == 0) ? 16 : (it == 1) ? 20 : int'($urandom_range(1, 15));
      w = {};
      for (int k = 0; k < 16; k++) begin
        w.push_back(mov_imm(3'($urandom_range(0, 7)), 8'($urandom)));
        write_mem(k, w[k]);
      end
      ne = (c > 16) ? 16 : c;
      for (int r = 0; r < 8; r++) begin exp_rf[r] = '0; wr[r] = 1'b0; end
      for (int k = 0; k < ne; k++) begin
        exp_rf[w[k][RN_HI:RN_LO]] = sext8(w[k][IMM8_HI:IMM8_LO]);
        wr[w[k][RN_HI:RN_LO]]     = 1'b1;
      end
      kick(c);
      n = 1;
      wait_done(n);
      finish_run("rand", ne, w, n);
      for (int r = 0; r < 8; r++)
        if (wr[r]) chk("rand_reg", 32'(rf[r]), 32'(exp_rf[r]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Drives a stored program into the `cpu` block over its `in`/`load`/`s`/`w` instruction handshake. It fills the instruction register, pulses start, and waits for the CPU to return to its wait state before issuing the next instruction. It replaces hand-written load/start/wait stimulus and sits above `cpu` in board-level and bench top levels. It holds a small writable instruction memory, and programs are loaded through a separate write port before execution.

## Interface
- `DEPTH`, 16: instruction memory entries; must be a power of 2.
- `AW`, 4: address width, equal to log2(`DEPTH`).
- `TIMEOUT`, 64: maximum cycles to wait for each `w` edge before flagging an error.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `prog_we` input 1: write `prog_data` to `prog_addr`; ignored while `busy`.
- `prog_addr` input `AW`: write address.
- `prog_data` input 16: instruction word.
- `count` input `AW`+1: number of instructions to run, 0 to `DEPTH`; sampled on `start`.
- `start` input 1: begin execution at address 0; ignored while `busy`.
- `cpu_w` input 1: CPU `w` output.
- `cpu_in` output 16: to CPU `in`.
- `cpu_load` output 1: to CPU `load`.
- `cpu_s` output 1: to CPU `s`.
- `pc` output `AW`+1: index of the current or next instruction.
- `busy` output 1: high from the cycle after an accepted `start` until DONE or ERR.
- `done` output 1: one-cycle pulse after the last instruction completes.
- `err` output 1: sticky timeout flag; cleared by `reset` or the next accepted `start`.

## Operation
- On reset, every output is 0: `cpu_in`=0, `cpu_load`=0, `cpu_s`=0, `pc`=0, `busy`=0, `done`=0, `err`=0. The state is IDLE.
- Reset does not clear the memory, and its contents after power-up are undefined.
- States are IDLE, LOAD, STRT, WLOW, WHIGH, DONE and ERR.
- IDLE:
  - `start`=1 latches `count`, clears `pc` and `err`, and sets `busy`.
  - If `count` is 0, the next state is DONE. Otherwise the next state is LOAD.
- LOAD: `cpu_in`=mem[`pc`] and `cpu_load`=1 for exactly one cycle. Next state is STRT.
- STRT: `cpu_s`=1 for exactly one cycle, with `cpu_load`=0. `cpu_in` holds its value. Next state is WLOW.
- WLOW: waits for `cpu_w`=0, meaning the CPU has left its wait state. Next state is WHIGH.
- WHIGH: waits for `cpu_w`=1.
  - On that cycle, `pc` increments.
  - If the new `pc` equals `count`, the next state is DONE. Otherwise the next state is LOAD.
- DONE: `done`=1 for one cycle and `busy`=0. Next state is IDLE.
- ERR: entered when either WLOW or WHIGH lasts `TIMEOUT` cycles.
  - `err`=1 and `busy`=0. `pc` holds the index of the failing instruction.
  - Stays in ERR until `start` is accepted, which behaves as in IDLE.
- A single timeout counter is cleared on entry to WLOW and again on entry to WHIGH.
- `pc` arithmetic is unsigned, `AW`+1 bits wide, and never exceeds `count`.
- `count` values above `DEPTH` are clamped to `DEPTH`.
- A `prog_we` in the same cycle as an accepted `start` performs the write first. The first LOAD sees the new data.

## Timing
- An accepted `start` at edge t puts `cpu_load`=1 during cycle t+1 and `cpu_s`=1 during cycle t+2.
- Back-to-back issue: the LOAD for the next instruction is the cycle right after `cpu_w` is sampled high in WHIGH.
  - The minimum overhead is 3 sequencer cycles per instruction plus the CPU's execution time.
- `cpu_load` and `cpu_s` are registered outputs and are never high in the same cycle.
- Reset asserted mid-program immediately forces all outputs to 0, the state to IDLE, and the program is abandoned. The CPU must be reset alongside the sequencer.
- Memory: synchronous write on `clk`, combinational read. The read data is registered into `cpu_in` on entry to LOAD.

## Structure
- `seq_pkg` holds:
  - the state enum `seq_state_t`;
  - the instruction field constants (opcode, op, rn/rd/rm and sh positions) shared with `cpu` and the benches;
  - helper functions that build MOV-immediate and ALU instruction words.
- Sub-module `instr_mem` is a `DEPTH`×16 register array with one write port and one asynchronous read port.
- The FSM, timeout counter and `pc` logic live in `instr_sequencer`.

## Test plan
- **Single MOV.** Write mem[0]=16'hD004 (MOV R0,#4), `count`=1, pulse `start` with the real `cpu` attached.
  - Expect `cpu_load` on cycle t+1 and `cpu_s` on t+2, then `done`.
  - R0=16'h0004 and `pc`=1.
- **Five-instruction program.** Load:
  - MOV R2,#33 = 16'hD233
  - MOV R3,#2 = 16'hD302
  - ADD R0,R2,R3,LSL#1 = 16'hA20B
  - AND R3,R2,R1, with MOV R1,#24 = 16'hD124 preloaded first
  - MVN R3,R0 = 16'hB860

  Expect R0=16'h0037, R3=16'hFFC8 and a single `done` pulse.
- **Zero count.** `count`=0 -> `done` at t+1, with no `cpu_load` or `cpu_s` ever asserted.
- **Timeout.** Stub the CPU with `cpu_w` stuck at 1 -> `err`=1 exactly `TIMEOUT` cycles after entry to WLOW, with `pc`=0 and `busy`=0.
  - A following valid `start` clears `err`.
- **Reset mid-program.** Assert `reset`=0 while in WHIGH on instruction 2 -> all outputs 0 asynchronously.
  - Restarting after reset re-runs from `pc`=0, and the memory contents are preserved.
- **Ignored inputs while busy.** `start` and `prog_we` pulses while `busy` -> no restart and memory unchanged, checked by reading back through a later run.
